// File: rtl/fw_loader_pkg.sv
// Purpose: shared types and default constants for the firmware loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fw_loader_pkg;

    // CHK is only reachable when FW_LOADER_CHECKSUM_EN is defined.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHK,
        VEC_LO,
        VEC_HI,
        HOLD,
        DONE,
        ERR
    } fw_ld_state_t;

    localparam logic [15:0] FW_RST_VEC_ADDR = 16'hFFFC;
    localparam int          FW_RESET_HOLD   = 4;

endpackage

// File: rtl/fw_loader.sv
// Purpose: streams a firmware image into 6502 memory, writes the reset vector, then releases the CPU.
// Latency: one cycle from byte handshake to memory write; vector writes follow, then RESET_HOLD cycles.
// Backpressure: byte_ready high only in LOAD (and CHK); no other stall sources.
//
// Ports:
//   clk, reset_n              loader clock, synchronous active-low reset
//   start                     1-cycle pulse, begins a load from IDLE/DONE/ERR
//   byte_valid/_data/_last    image byte stream in; byte_ready accepts it
//   mem_we/_addr/_din         registered memory write port
//   cpu_reset_n               CPU reset, released only in DONE
//   busy, done, err           status (done/err hold until the next start)
//   byte_count                bytes accepted in the current load
// Optional feature: define FW_LOADER_CHECKSUM_EN to require a trailing two's-complement
// checksum byte after byte_last; a mismatch ends in ERR.
module fw_loader
    import fw_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    REG_WIDTH    = 8,
    parameter logic [ADDR_WIDTH-1:0] LOAD_BASE    = ADDR_WIDTH'(16'h0200),
    parameter int                    MAX_BYTES    = 1024,
    parameter logic [ADDR_WIDTH-1:0] RST_VEC_ADDR = ADDR_WIDTH'(FW_RST_VEC_ADDR),
    parameter int                    RESET_HOLD   = FW_RESET_HOLD
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [REG_WIDTH-1:0]  byte_data,
    input  logic                  byte_last,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]  mem_din,
    output logic                  cpu_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] byte_count
);

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(MAX_BYTES);

    // The image must never run into the reset vector; this also rules out address wrap.
    if (int'(LOAD_BASE) + MAX_BYTES > int'(RST_VEC_ADDR)) begin : g_bad_params
        $error("fw_loader: LOAD_BASE + MAX_BYTES exceeds RST_VEC_ADDR");
    end

    fw_ld_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REG_WIDTH-1:0]  din_q, din_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
`ifdef FW_LOADER_CHECKSUM_EN
    logic [REG_WIDTH-1:0]  sum_q, sum_d;
`endif
    logic                  hs;

    assign byte_ready  = (state_q == LOAD) || (state_q == CHK);
    assign hs          = byte_valid && byte_ready;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_din     = din_q;
    assign byte_count  = cnt_q;
    assign cpu_reset_n = (state_q == DONE);
    assign done        = (state_q == DONE);
    assign err         = (state_q == ERR);
    assign busy        = (state_q == LOAD) || (state_q == CHK) || (state_q == VEC_LO) ||
                         (state_q == VEC_HI) || (state_q == HOLD);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        hold_d  = hold_q;
`ifdef FW_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
`ifdef FW_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            LOAD: begin
                if (hs) begin
                    if (cnt_q == MAX_CNT) begin
                        // Image too large: drop the byte, no write.
                        state_d = ERR;
                    end else begin
                        we_d   = 1'b1;
                        addr_d = LOAD_BASE + cnt_q;
                        din_d  = byte_data;
                        cnt_d  = cnt_q + ADDR_WIDTH'(1);
`ifdef FW_LOADER_CHECKSUM_EN
                        sum_d  = sum_q + byte_data;
                        if (byte_last) state_d = CHK;
`else
                        if (byte_last) state_d = VEC_LO;
`endif
                    end
                end
            end
`ifdef FW_LOADER_CHECKSUM_EN
            CHK: begin
                // Checksum byte is consumed but never written to memory.
                if (hs) begin
                    state_d = ((sum_q + byte_data) == '0) ? VEC_LO : ERR;
                end
            end
`endif
            VEC_LO: begin
                we_d    = 1'b1;
                addr_d  = RST_VEC_ADDR;
                din_d   = REG_WIDTH'(LOAD_BASE);
                state_d = VEC_HI;
            end
            VEC_HI: begin
                we_d    = 1'b1;
                addr_d  = RST_VEC_ADDR + ADDR_WIDTH'(1);
                din_d   = REG_WIDTH'(LOAD_BASE >> REG_WIDTH);
                hold_d  = '0;
                state_d = HOLD;
            end
            HOLD: begin
                if (hold_q == HOLD_W'(RESET_HOLD - 1)) begin
                    state_d = DONE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            hold_q  <= '0;
`ifdef FW_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            hold_q  <= hold_d;
`ifdef FW_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_fw_loader.sv
`timescale 1ns/1ps
module tb_fw_loader;

    localparam int          AW     = 16;
    localparam int          RW     = 8;
    localparam int          MAXB   = 4;
    localparam int          HOLD_N = 4;
    localparam logic [15:0] BASE   = 16'h0200;
    localparam logic [15:0] RVEC   = 16'hFFFC;
`ifdef FW_LOADER_CHECKSUM_EN
    localparam int          VLO_GAP = 2;
`else
    localparam int          VLO_GAP = 1;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          byte_valid = 1'b1;
    logic [RW-1:0] byte_data = '0;
    logic          byte_last = 1'b0;
    logic          byte_ready, mem_we, cpu_reset_n, busy, done, err;
    logic [AW-1:0] mem_addr, byte_count;
    logic [RW-1:0] mem_din;

    fw_loader #(
        .ADDR_WIDTH  (AW),
        .REG_WIDTH   (RW),
        .LOAD_BASE   (BASE),
        .MAX_BYTES   (MAXB),
        .RST_VEC_ADDR(RVEC),
        .RESET_HOLD  (HOLD_N)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .cpu_reset_n(cpu_reset_n),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [23:0] exp_q[$];
    int          wcyc_q[$];
    int          vec_hi_cyc = -1;
    int          rise_cyc = -1;
    logic        rst_prev = 1'b0;
    logic [7:0]  img_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write-port monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        logic [23:0] e;
        if (mem_we === 1'b1) begin
            wcyc_q.push_back(cyc);
            if (mem_addr == RVEC + 16'h1) vec_hi_cyc = cyc;
            if (exp_q.size() == 0) begin
                check_eq("unexp_wr", {8'h00, mem_addr, mem_din}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_eq("wr_addr", {16'h0, mem_addr}, {16'h0, e[23:8]});
                check_eq("wr_data", {24'h0, mem_din}, {24'h0, e[7:0]});
            end
        end
        if (cpu_reset_n === 1'b1 && rst_prev === 1'b0) rise_cyc = cyc;
        rst_prev = cpu_reset_n;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = last;
        while (byte_ready !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        if (byte_ready !== 1'b1) check_eq("rdy_timeout", {31'h0, byte_ready}, 32'h1);
        tick(1);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    // Sends img_q (plus checksum byte when enabled) and queues the writes the loader must make.
    task automatic load_image(input int gap, input bit bad_chk);
`ifdef FW_LOADER_CHECKSUM_EN
        logic [7:0] sum = 8'h00;
`endif
        for (int i = 0; i < img_q.size(); i++) begin
            if (i < MAXB) begin
                exp_q.push_back({BASE + 16'(i), img_q[i]});
`ifdef FW_LOADER_CHECKSUM_EN
                sum = sum + img_q[i];
`endif
            end
            send_byte(img_q[i], i == img_q.size() - 1);
            if (gap > 0 && i != img_q.size() - 1) tick(gap);
        end
`ifdef FW_LOADER_CHECKSUM_EN
        if (img_q.size() <= MAXB) send_byte(bad_chk ? 8'(8'h01 - sum) : 8'(8'h00 - sum), 1'b0);
`endif
        if (img_q.size() <= MAXB && !bad_chk) begin
            exp_q.push_back({RVEC, BASE[7:0]});
            exp_q.push_back({RVEC + 16'h1, BASE[15:8]});
        end
    endtask

    task automatic wait_settle();
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        if (busy !== 1'b0) check_eq("busy_timeout", {31'h0, busy}, 32'h0);
        tick(1);
    endtask

    initial begin
        // Reset with byte_valid asserted: everything quiet.
        tick(3);
        check_eq("rst_cpu_reset_n", {31'h0, cpu_reset_n}, 32'h0);
        check_eq("rst_byte_ready",  {31'h0, byte_ready},  32'h0);
        check_eq("rst_mem_we",      {31'h0, mem_we},      32'h0);
        check_eq("rst_byte_count",  {16'h0, byte_count},  32'h0);
        check_eq("rst_mem_addr",    {16'h0, mem_addr},    32'h0);
        check_eq("rst_busy_done_err", {29'h0, busy, done, err}, 32'h0);
        reset_n = 1'b1;
        byte_valid = 1'b0;
        tick(2);

        // Back-to-back image.
        img_q = '{8'hA9, 8'h01, 8'h8D};
        wcyc_q.delete();
        pulse_start();
        check_eq("ld_busy", {31'h0, busy}, 32'h1);
        check_eq("ld_cpu_reset_n", {31'h0, cpu_reset_n}, 32'h0);
        load_image(0, 1'b0);
        wait_settle();
        check_eq("b2b_done", {31'h0, done}, 32'h1);
        check_eq("b2b_cpu_reset_n", {31'h0, cpu_reset_n}, 32'h1);
        check_eq("b2b_err", {31'h0, err}, 32'h0);
        check_eq("b2b_count", {16'h0, byte_count}, 32'd3);
        check_eq("b2b_hold_gap", 32'(rise_cyc - vec_hi_cyc), 32'd4);
        check_eq("b2b_wr_count", 32'(wcyc_q.size()), 32'd5);
        if (wcyc_q.size() == 5) begin
            check_eq("b2b_consec", 32'(wcyc_q[2] - wcyc_q[0]), 32'd2);
            check_eq("b2b_vlo_gap", 32'(wcyc_q[3] - wcyc_q[2]), 32'(VLO_GAP));
        end
        check_eq("b2b_sb_drain", 32'(exp_q.size()), 32'd0);

        // Same image with gaps, restarted from DONE.
        wcyc_q.delete();
        pulse_start();
        check_eq("restart_done_clr", {31'h0, done}, 32'h0);
        check_eq("restart_cpu_reset_n", {31'h0, cpu_reset_n}, 32'h0);
        load_image(1, 1'b0);
        wait_settle();
        check_eq("gap_done", {31'h0, done}, 32'h1);
        if (wcyc_q.size() >= 2) check_eq("gap_spacing", 32'(wcyc_q[1] - wcyc_q[0]), 32'd2);
        check_eq("gap_sb_drain", 32'(exp_q.size()), 32'd0);

        // Overflow: five bytes into a four-byte limit.
        img_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        wcyc_q.delete();
        pulse_start();
        load_image(0, 1'b0);
        tick(8);
        check_eq("ovf_err", {31'h0, err}, 32'h1);
        check_eq("ovf_done", {31'h0, done}, 32'h0);
        check_eq("ovf_cpu_reset_n", {31'h0, cpu_reset_n}, 32'h0);
        check_eq("ovf_count", {16'h0, byte_count}, 32'd4);
        check_eq("ovf_wr_count", 32'(wcyc_q.size()), 32'd4);
        check_eq("ovf_sb_drain", 32'(exp_q.size()), 32'd0);

        // Exactly MAX_BYTES is legal, and start clears err.
        img_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        pulse_start();
        check_eq("max_err_clr", {31'h0, err}, 32'h0);
        load_image(0, 1'b0);
        wait_settle();
        check_eq("max_done", {31'h0, done}, 32'h1);
        check_eq("max_count", {16'h0, byte_count}, 32'd4);
        check_eq("max_sb_drain", 32'(exp_q.size()), 32'd0);

        // Reset mid-load after two bytes.
        pulse_start();
        exp_q.push_back({BASE, 8'hA9});
        exp_q.push_back({BASE + 16'h1, 8'h01});
        send_byte(8'hA9, 1'b0);
        send_byte(8'h01, 1'b0);
        reset_n = 1'b0;
        byte_valid = 1'b1;
        tick(2);
        check_eq("mid_rst_count", {16'h0, byte_count}, 32'h0);
        check_eq("mid_rst_busy", {31'h0, busy}, 32'h0);
        check_eq("mid_rst_cpu_reset_n", {31'h0, cpu_reset_n}, 32'h0);
        reset_n = 1'b1;
        byte_valid = 1'b0;
        tick(4);
        check_eq("mid_rst_sb_drain", 32'(exp_q.size()), 32'd0);
        img_q = '{8'hA9, 8'h01, 8'h8D};
        pulse_start();
        load_image(0, 1'b0);
        wait_settle();
        check_eq("reload_done", {31'h0, done}, 32'h1);
        check_eq("reload_sb_drain", 32'(exp_q.size()), 32'd0);

`ifdef FW_LOADER_CHECKSUM_EN
        // Checksum good then bad.
        img_q = '{8'h01, 8'h02};
        pulse_start();
        load_image(0, 1'b0);
        wait_settle();
        check_eq("chk_good_done", {31'h0, done}, 32'h1);
        pulse_start();
        load_image(0, 1'b1);
        tick(8);
        check_eq("chk_bad_err", {31'h0, err}, 32'h1);
        check_eq("chk_bad_cpu_reset_n", {31'h0, cpu_reset_n}, 32'h0);
        check_eq("chk_bad_sb_drain", 32'(exp_q.size()), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
